// File: rtl/val2_pkg.sv
// Shared constants and types for the serial Val2 shifter-operand generator.
package val2_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Rotated-immediate form rotates right by twice the 4-bit rotate field.
  function automatic logic [4:0] imm_rot_steps(input logic [3:0] rot);
    return {rot, 1'b0};
  endfunction

endpackage

// File: rtl/val2_shift_sequencer_if.sv
// Request/result bundle for val2_shift_sequencer.
// With VAL2_CARRY_OUT_EN defined, adds c_in and shifter_carry.
interface val2_shift_sequencer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              mem_cmd;
  logic              imm;
  logic [DATA_W-1:0] rm;
  logic [11:0]       shift_operand;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] val2;
`ifdef VAL2_CARRY_OUT_EN
  logic              c_in;
  logic              shifter_carry;
`endif

  modport master (
    output start, mem_cmd, imm, rm, shift_operand,
`ifdef VAL2_CARRY_OUT_EN
    output c_in,
    input  shifter_carry,
`endif
    input  busy, valid, val2
  );

  modport slave (
    input  start, mem_cmd, imm, rm, shift_operand,
`ifdef VAL2_CARRY_OUT_EN
    input  c_in,
    output shifter_carry,
`endif
    output busy, valid, val2
  );

endinterface

// File: rtl/val2_shift_step.sv
// One-bit shift/rotate step of the serial Val2 datapath; bit_out is the bit
// shifted or rotated out by this step.
module val2_shift_step
  import val2_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] next_acc,
  output logic              bit_out
);

  always_comb begin
    next_acc = acc;
    bit_out  = 1'b0;
    unique case (op)
      SH_LSL: begin
        next_acc = {acc[DATA_W-2:0], 1'b0};
        bit_out  = acc[DATA_W-1];
      end
      SH_LSR: begin
        next_acc = {1'b0, acc[DATA_W-1:1]};
        bit_out  = acc[0];
      end
      SH_ASR: begin
        next_acc = {acc[DATA_W-1], acc[DATA_W-1:1]};
        bit_out  = acc[0];
      end
      SH_ROR: begin
        next_acc = {acc[0], acc[DATA_W-1:1]};
        bit_out  = acc[0];
      end
    endcase
  end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle Val2 generator: one shift/rotate step per clock, valid pulses
// N+1 cycles after accept. Optional carry output under VAL2_CARRY_OUT_EN.
module val2_shift_sequencer
  import val2_pkg::*;
#(
  parameter int unsigned DATA_W = 32,  // only 32 is supported
  parameter int unsigned CNT_W  = 6
) (
  input logic                   clk,
  input logic                   rst,
  val2_shift_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;

  logic [DATA_W-1:0] load_acc;
  logic [4:0]        load_n;
  logic [1:0]        load_op;
  logic [DATA_W-1:0] step_acc;
  logic              step_bit;
  logic              done_load;

  val2_shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .acc      (acc_q),
    .op       (op_q),
    .next_acc (step_acc),
    .bit_out  (step_bit)
  );

  // Operand decode; mem_cmd outranks imm.
  always_comb begin
    load_acc = bus.rm;
    load_n   = bus.shift_operand[11:7];
    load_op  = bus.shift_operand[6:5];
    if (bus.mem_cmd) begin
      load_acc = {{(DATA_W-12){bus.shift_operand[11]}}, bus.shift_operand};
      load_n   = 5'd0;
      load_op  = SH_LSL;
    end else if (bus.imm) begin
      load_acc = {{(DATA_W-8){1'b0}}, bus.shift_operand[7:0]};
      load_n   = imm_rot_steps(bus.shift_operand[11:8]);
      load_op  = SH_ROR;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    val2_d    = val2_q;
    done_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d = load_acc;
          op_d  = load_op;
          cnt_d = CNT_W'(load_n);
          if (load_n == 5'd0) begin
            state_d   = S_DONE;
            val2_d    = load_acc;
            done_load = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          val2_d    = step_acc;
          done_load = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      val2_q  <= '0;
      cnt_q   <= '0;
      op_q    <= SH_LSL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      val2_q  <= val2_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.valid = (state_q == S_DONE);
  assign bus.val2  = val2_q;

`ifdef VAL2_CARRY_OUT_EN
  logic carry_q;

  // Zero-step results pass c_in through; otherwise keep the last bit out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (done_load) begin
      carry_q <= (state_q == S_SHIFT) ? step_bit : bus.c_in;
    end
  end

  assign bus.shifter_carry = carry_q;
`else
  logic unused_step_bit;
  assign unused_step_bit = step_bit;
`endif

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Scoreboard bench for val2_shift_sequencer: stimulus pushes expected results,
// a negedge monitor pops and checks value, latency and (optionally) carry.
module tb_val2_shift_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    logic        carry;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_val2 = '0;

  val2_shift_sequencer_if #(.DATA_W(32)) bus ();

  val2_shift_sequencer #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      last_val2 = '0;
    end else if (bus.valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_valid: got val2=%h at cycle %0d, required no valid", bus.val2,
                 cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.val2 !== e.val) begin
          n_mis++;
          $display("FAIL val2: got %h, required %h", bus.val2, e.val);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_mis++;
          $display("FAIL latency: valid at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
`ifdef VAL2_CARRY_OUT_EN
        n_cmp++;
        if (bus.shifter_carry !== e.carry) begin
          n_mis++;
          $display("FAIL carry: got %b, required %b", bus.shifter_carry, e.carry);
        end
`endif
      end
      last_val2 = bus.val2;
    end else begin
      n_cmp++;
      if (bus.val2 !== last_val2) begin
        n_mis++;
        $display("FAIL val2_hold: got %h between pulses, required %h", bus.val2, last_val2);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Drives one request during a cycle; returns one cycle after the accept.
  task automatic issue(input logic m, input logic i, input logic [31:0] r,
                       input logic [11:0] so, input logic cin, input logic [31:0] ev,
                       input int n, input logic ecarry);
    exp_t e;
    @(negedge clk); #1;
    bus.start         = 1'b1;
    bus.mem_cmd       = m;
    bus.imm           = i;
    bus.rm            = r;
    bus.shift_operand = so;
`ifdef VAL2_CARRY_OUT_EN
    bus.c_in          = cin;
`else
    if (cin) begin end
`endif
    e.val   = ev;
    e.cyc   = cyc + n + 1;
    e.carry = ecarry;
    sb_q.push_back(e);
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb_q.size() != 0 && k < 64) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.mem_cmd       = 1'b0;
    bus.imm           = 1'b0;
    bus.rm            = '0;
    bus.shift_operand = '0;
`ifdef VAL2_CARRY_OUT_EN
    bus.c_in          = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_val2", bus.val2, 32'd0);
`ifdef VAL2_CARRY_OUT_EN
    check("reset_carry", 32'(bus.shifter_carry), 32'd0);
`endif
    rst = 1'b1;

    // Memory offset, back to back; carry passes c_in through.
    issue(1'b1, 1'b0, 32'h0, 12'hFFC, 1'b1, 32'hFFFF_FFFC, 0, 1'b1);
    issue(1'b1, 1'b0, 32'h0, 12'h7FF, 1'b0, 32'h0000_07FF, 0, 1'b0);
    drain("mem");
    // mem_cmd outranks imm
    issue(1'b1, 1'b1, 32'h0, 12'h7FF, 1'b1, 32'h0000_07FF, 0, 1'b1);
    drain("prio");

    // Rotated immediate with busy window check (busy in cycles 1..9)
    issue(1'b0, 1'b1, 32'h0, 12'h4FF, 1'b0, 32'hFF00_0000, 8, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("imm_busy_c%0d", k), 32'(bus.busy), (k <= 9) ? 32'd1 : 32'd0);
      @(negedge clk); #1;
    end
    drain("imm");

    // Register-specified shifts
    issue(1'b0, 1'b0, 32'h0000_0001, 12'h200, 1'b0, 32'h0000_0010, 4, 1'b0);
    drain("lsl4");
    issue(1'b0, 1'b0, 32'h1234_5678, 12'h460, 1'b0, 32'h7812_3456, 8, 1'b0);
    drain("ror8");
    issue(1'b0, 1'b0, 32'h8000_0000, 12'hFC0, 1'b0, 32'hFFFF_FFFF, 31, 1'b0);
    drain("asr31");
    issue(1'b0, 1'b0, 32'h8000_0000, 12'hFA0, 1'b0, 32'h0000_0001, 31, 1'b0);
    drain("lsr31");
    issue(1'b0, 1'b0, 32'h0000_0003, 12'h0A0, 1'b0, 32'h0000_0001, 1, 1'b1);
    drain("lsr1");

    // Start pulsed in cycle 3 of a busy operation must be ignored.
    issue(1'b0, 1'b1, 32'h0, 12'h4FF, 1'b0, 32'hFF00_0000, 8, 1'b1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    bus.start         = 1'b1;
    bus.mem_cmd       = 1'b1;
    bus.shift_operand = 12'h123;
    @(negedge clk); #1;
    bus.start   = 1'b0;
    bus.mem_cmd = 1'b0;
    drain("ignored_start");
    repeat (12) @(negedge clk);
    #1;

    // Reset in cycle 4 aborts the operation with no valid.
    issue(1'b0, 1'b1, 32'h0, 12'h4FF, 1'b0, 32'hFF00_0000, 8, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    sb_q.delete();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_val2", bus.val2, 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    issue(1'b0, 1'b0, 32'h0000_0001, 12'h200, 1'b0, 32'h0000_0010, 4, 1'b0);
    drain("after_reset");
    repeat (4) @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
